// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and helpers shared by the
// multiply/divide sequencer, its interface and its bench.
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } muldiv_state_e;

    function automatic logic is_muldiv_start(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    function automatic logic is_hilo_use(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage <-> multiply/divide unit bundle.
// master = EX stage, slave = muldiv_ctrl.
interface muldiv_ctrl_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
);
    logic            ex_valid_i;
    logic [3:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic [XLEN-1:0] hilo_rdata_o;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;

    modport master (
        output ex_valid_i, op_i, a_i, b_i, flush_i,
        input  stall_o, busy_o, hilo_rdata_o, hi_o, lo_o
    );

    modport slave (
        input  ex_valid_i, op_i, a_i, b_i, flush_i,
        output stall_o, busy_o, hilo_rdata_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one shift-add multiply step or one restoring
// divide step on a 2*XLEN accumulator, purely combinational.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shl;
    logic [XLEN:0] diff;

    // Mul: acc={partial,multiplier}; div: acc={remainder,dividend}
    always_comb begin
        sum  = {1'b0, acc_i[2*XLEN-1:XLEN]}
             + {1'b0, (acc_i[0] ? opnd_i : {XLEN{1'b0}})};
        shl  = acc_i[2*XLEN-1:XLEN-1];
        diff = shl - {1'b0, opnd_i};
        if (!div_i) begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = {shl[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/DIV sequencer with HI/LO registers.
// MULDIV_FAST_MUL_EN selects a single-cycle multiply.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MULDIV_XLEN,
    parameter int CNT_W = $clog2(XLEN)
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_ctrl_if.slave ex
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    muldiv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] mul_res;
    logic              mul_done;
    logic              signed_op;
    logic              mul_op;
    logic              busy;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN-1:0]   quot, rem;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .div_i  (state_q == ST_DIV),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    // Decode the incoming op and form operand magnitudes
    always_comb begin
        signed_op = (ex.op_i == OP_MULT) || (ex.op_i == OP_DIV);
        mul_op    = (ex.op_i == OP_MULT) || (ex.op_i == OP_MULTU);
        a_mag = (signed_op && ex.a_i[XLEN-1]) ? -ex.a_i : ex.a_i;
        b_mag = (signed_op && ex.b_i[XLEN-1]) ? -ex.b_i : ex.b_i;
    end

    // Multiply result source and divide result split
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        mul_res  = {{XLEN{1'b0}}, acc_q[XLEN-1:0]}
                 * {{XLEN{1'b0}}, opnd_q};
        mul_done = 1'b1;
`else
        mul_res  = step_acc;
        mul_done = (cnt_q == CNT_LAST);
`endif
        quot = step_acc[XLEN-1:0];
        rem  = step_acc[2*XLEN-1:XLEN];
    end

    // Next state, iteration and HI/LO update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ex.ex_valid_i && !ex.flush_i) begin
                    if (is_muldiv_start(ex.op_i)) begin
                        cnt_d    = '0;
                        acc_d    = {{XLEN{1'b0}}, a_mag};
                        opnd_d   = b_mag;
                        neg_lo_d = signed_op
                                 && (ex.a_i[XLEN-1] ^ ex.b_i[XLEN-1]);
                        neg_hi_d = signed_op && ex.a_i[XLEN-1];
                        if (mul_op) begin
                            state_d = ST_MUL;
                        end else begin
                            state_d = ST_DIV;
                            // Divide by zero returns raw a in HI
                            if (ex.b_i == '0) begin
                                acc_d    = {{XLEN{1'b0}}, ex.a_i};
                                neg_lo_d = 1'b0;
                                neg_hi_d = 1'b0;
                            end
                        end
                    end else if (ex.op_i == OP_MTHI) begin
                        hi_d = ex.a_i;
                    end else if (ex.op_i == OP_MTLO) begin
                        lo_d = ex.a_i;
                    end
                end
            end
            ST_MUL: begin
                if (ex.flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = mul_res;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (mul_done) begin
                        state_d      = ST_IDLE;
                        cnt_d        = '0;
                        {hi_d, lo_d} = neg_lo_q ? -mul_res : mul_res;
                    end
                end
            end
            ST_DIV: begin
                if (ex.flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        lo_d    = neg_lo_q ? -quot : quot;
                        hi_d    = neg_hi_q ? -rem : rem;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign ex.busy_o       = busy;
    assign ex.stall_o      = rst_n && ex.ex_valid_i && busy
                           && is_hilo_use(ex.op_i) && !ex.flush_i;
    assign ex.hilo_rdata_o = (ex.op_i == OP_MFHI) ? hi_q
                           : (ex.op_i == OP_MFLO) ? lo_q
                           : '0;
    assign ex.hi_o         = hi_q;
    assign ex.lo_o         = lo_q;
endmodule
